// File: rtl/sccpu_dbg_pkg.sv
// sccpu_dbg_pkg: trace buffer state encoding and trace entry layout
package sccpu_dbg_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} trace_state_e;
   localparam int WMEM_OFF = 0;
   localparam int WREG_OFF = 1;
   localparam int RFWN_OFF = 2;
   localparam int DATA_OFF = 7;
   function automatic int trace_w(input int addr_w, input int data_w);
      return addr_w + data_w + 7;
   endfunction
endpackage

// File: rtl/sccpu_trace_ram.sv
// sccpu_trace_ram: DEPTH x W trace storage, synchronous write, asynchronous read
module sccpu_trace_ram #(
   parameter int W = 71,
   parameter int DEPTH = 64,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             we,
   input  logic [PTR_W-1:0] wa,
   input  logic [W-1:0]     wd,
   input  logic [PTR_W-1:0] ra,
   output logic [W-1:0]     rd
);
   logic [W-1:0] mem_q [DEPTH];
   always_ff @(posedge clock) begin
      if (we) mem_q[wa] <= wd;
   end
   assign rd = mem_q[ra];
endmodule

// File: rtl/sccpu_trace_buffer.sv
// sccpu_trace_buffer: trigger-stopped circular trace of CPU activity, read out oldest-first
module sccpu_trace_buffer
   import sccpu_dbg_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH = 64,
   parameter int PTR_W = $clog2(DEPTH),
   localparam int TW = trace_w(ADDR_W, DATA_W)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cap_en,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data,
   input  logic [4:0]        rf_wn,
   input  logic              cu_wreg,
   input  logic              cu_wmem,
   input  logic              arm,
   input  logic [ADDR_W-1:0] trig_addr,
   input  logic [PTR_W:0]    post_cnt,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [TW-1:0]     rd_data,
   output logic              rd_last,
   output logic [1:0]        state,
   output logic [PTR_W:0]    fill_count
);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] MAXP = (PTR_W+1)'(DEPTH - 1);
   localparam logic [PTR_W:0] ONE = (PTR_W+1)'(1);
   trace_state_e state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0] fill_q, fill_d, rem_q, rem_d, post_q, post_d, rd_rem_q, rd_rem_d;
   logic [ADDR_W-1:0] trig_q, trig_d;
   logic loaded_q, loaded_d;
   logic cap;
   logic [TW-1:0] ram_rd;
   assign cap = !arm && cap_en && (state_q == ARMED || state_q == POST);
   always_comb begin
      state_d = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d = fill_q;
      rem_d = rem_q;
      post_d = post_q;
      rd_rem_d = rd_rem_q;
      trig_d = trig_q;
      loaded_d = loaded_q;
      if (arm) begin
         state_d = ARMED;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         fill_d = '0;
         rem_d = '0;
         rd_rem_d = '0;
         loaded_d = 1'b0;
         trig_d = trig_addr;
         post_d = post_cnt > MAXP ? MAXP : post_cnt;
      end else if (cap) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
         fill_d = fill_q == FULL ? fill_q : fill_q + ONE;
         if (state_q == POST) begin
            rem_d = rem_q - ONE;
            state_d = rem_q == ONE ? DONE : POST;
         end else if (address == trig_q) begin
            state_d = post_q == '0 ? DONE : POST;
            rem_d = post_q;
         end
      end else if (state_q == DONE && !loaded_q) begin
         // oldest entry sits fill_count slots behind the write pointer
         loaded_d = 1'b1;
         rd_ptr_d = wr_ptr_q - fill_q[PTR_W-1:0];
         rd_rem_d = fill_q;
      end else if (rd_valid && rd_ready) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         rd_rem_d = rd_rem_q - ONE;
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q <= '0;
         rem_q <= '0;
         post_q <= '0;
         rd_rem_q <= '0;
         trig_q <= '0;
         loaded_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q <= fill_d;
         rem_q <= rem_d;
         post_q <= post_d;
         rd_rem_q <= rd_rem_d;
         trig_q <= trig_d;
         loaded_q <= loaded_d;
      end
   end
   sccpu_trace_ram #(.W(TW), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
      .clock(clock),
      .we(cap),
      .wa(wr_ptr_q),
      .wd({address, data, rf_wn, cu_wreg, cu_wmem}),
      .ra(rd_ptr_q),
      .rd(ram_rd)
   );
   assign rd_valid = rd_rem_q != '0;
   assign rd_last = rd_rem_q == ONE;
   assign rd_data = rd_valid ? ram_rd : '0;
   assign state = state_q;
   assign fill_count = fill_q;
endmodule

// File: doc/sccpu_trace_buffer.md
Name: sccpu_trace_buffer

Overview:
- Synthesizable trace capture block attached to the single-cycle CPU's observation outputs.
- Records a per-cycle trace of {address, data, rf_wn, cu_wreg, cu_wmem} into a circular buffer.
- Stops a programmable number of cycles after an address-match trigger, then streams the frozen trace out oldest-first over a valid/ready port.
- Parametrised successor of the fixed CPU observation harness: generic address/data widths, configurable depth, trigger and post-trigger window.

Parameters:
- ADDR_W, 32, width of CPU address bus
- DATA_W, 32, width of CPU data bus
- DEPTH, 64, trace entries; power of two, >= 4
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- clock  in  1  rising-edge clock shared with the CPU
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- cap_en  in  1  CPU advanced this cycle; capture qualifier
- address  in  ADDR_W  CPU address (PC) of the current cycle
- data  in  DATA_W  CPU result/data bus of the current cycle
- rf_wn  in  5  register-file write index
- cu_wreg  in  1  register write enable
- cu_wmem  in  1  memory write enable
- arm  in  1  single-cycle pulse: clear trace and begin capture
- trig_addr  in  ADDR_W  trigger address, sampled on arm
- post_cnt  in  PTR_W+1  entries captured after trigger entry, sampled on arm, clamped to DEPTH-1
- rd_ready  in  1  consumer accepts rd_data
- rd_valid  out  1  rd_data holds a valid entry
- rd_data  out  ADDR_W+DATA_W+7  {address, data, rf_wn, cu_wreg, cu_wmem}
- rd_last  out  1  rd_data is the newest entry
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
- fill_count  out  PTR_W+1  valid entries held, saturates at DEPTH

Behaviour:
- Reset:
  - state=IDLE; wr_ptr, rd_ptr, fill_count, post counter all 0.
  - rd_valid=0, rd_last=0, rd_data=0.
  - Array contents are don't-care.
- IDLE: nothing captured. arm -> ARMED.
- arm (any state, including mid-capture or mid-readout):
  - Next cycle: state=ARMED, fill_count=0, wr_ptr=0, readout aborted (rd_valid=0).
  - trig_addr and post_cnt are latched.
  - arm has priority over a trigger or capture in the same cycle; that cycle is not captured.
- ARMED:
  - Each cycle with cap_en=1, write the entry at wr_ptr, wr_ptr++ (wraps mod DEPTH), fill_count++ saturating at DEPTH.
  - Overwrites the oldest entry once full.
  - Trigger: cap_en=1 and address==trig_addr. The trigger entry is captured.
    - Latched post_cnt==0 -> DONE.
    - Otherwise -> POST with remaining=post_cnt.
- POST:
  - Each cap_en=1 cycle captures as in ARMED and decrements remaining.
  - On the capture that brings remaining to 0 -> DONE.
  - Further address matches are ignored.
- DONE:
  - No capture.
  - Readout pointer rd_ptr = wr_ptr - fill_count (mod DEPTH), computed on entry.
  - rd_valid=1 while entries remain; rd_data = array[rd_ptr], combinational from a registered pointer.
  - Transfer when rd_valid&&rd_ready: rd_ptr++, remaining-read count--.
  - rd_last=1 when exactly one entry remains.
  - After the last transfer, rd_valid=0; state stays DONE until arm.
  - rd_ready while rd_valid=0 is ignored.
  - rd_data is stable while rd_valid&&!rd_ready.
- Latency:
  - Trigger capture to DONE: 1 cycle.
  - First rd_valid: the cycle after entering DONE.
- Boundary conditions:
  - cap_en=0 cycles are never recorded and do not decrement the post counter.
  - fill_count < DEPTH at DONE -> only fill_count entries are read.
  - post_cnt > DEPTH-1 is clamped to DEPTH-1, so the trigger entry is always retained.
  - Reset mid-readout or mid-capture returns to IDLE.

Decomposition:
- Shared package sccpu_dbg_pkg:
  - State encoding constants IDLE/ARMED/POST/DONE.
  - Entry field offsets and the TRACE_W = ADDR_W+DATA_W+7 function.
- One natural sub-module: sccpu_trace_ram.
  - DEPTH x TRACE_W register array.
  - Synchronous write, asynchronous read.
- Control FSM, pointers and counters live in the top.

Test Plan:
- Reset, then idle 10 cycles with cap_en=1 -> state=0, fill_count=0, rd_valid=0.
- Basic trigger: DEPTH=8, arm with trig_addr=0x10, post_cnt=2; feed address 0x00,0x04,...,0x1C, one per cap_en cycle -> DONE after 0x18; readout returns 0x00..0x18 (7 entries), rd_last on 0x18.
- Wrap: DEPTH=8, trig_addr=0x40, post_cnt=1; feed addresses 0x00..0x44 step 4 -> 8 entries, 0x28..0x44 in order; fill_count=8.
- Backpressure and gaps: toggle rd_ready 1/0 and interleave cap_en=0 during POST -> no duplicated or lost entries; gaps are not recorded; rd_data holds while stalled.
- post_cnt=0 and clamp: trigger entry is last, with rd_last on it; post_cnt=20 at DEPTH=8 -> exactly 7 post entries, trigger entry is oldest.
- arm asserted mid-readout and on a trigger-match cycle -> readout aborts, fill_count=0, state=ARMED, no trigger taken that cycle; synchronous reset mid-POST -> IDLE next cycle.
